// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared definitions for the AES serial front-end.
//   - key-size header codes and the matching key_len values
//   - header width
//   - link state enum
//   - hdr_to_len(): header code -> key length in bits
package aes_spi_pkg;

   localparam int HDR_W = 2;

   localparam logic [1:0] KS_128  = 2'b00;
   localparam logic [1:0] KS_192  = 2'b01;
   localparam logic [1:0] KS_256  = 2'b10;
   localparam logic [1:0] KS_RSVD = 2'b11;

   localparam logic [8:0] KLEN_128 = 9'd128;
   localparam logic [8:0] KLEN_192 = 9'd192;
   localparam logic [8:0] KLEN_256 = 9'd256;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_HDR       = 3'd1,
      ST_MSG       = 3'd2,
      ST_KEY       = 3'd3,
      ST_CHECK     = 3'd4,
      ST_WAIT_PROC = 3'd5,
      ST_TX_ARMED  = 3'd6,
      ST_TX        = 3'd7
   } state_t;

   // Reserved code maps to 128 here; callers reject it before using the result.
   function automatic logic [8:0] hdr_to_len(input logic [1:0] code);
      case (code)
         KS_192:  return KLEN_192;
         KS_256:  return KLEN_256;
         default: return KLEN_128;
      endcase
   endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: saturating bit counter shared by the receive and
// transmit paths of aes_spi_link.
//   clk_i, rst_ni   clock, async active-low reset
//   clr_i           force count to 0 (highest priority)
//   load_i          load load_val_i (second priority)
//   en_i            increment by one, holding at MAX
//   tc_val_i        terminal-count compare value
//   cnt_o           current count
//   tc_o            cnt_o == tc_val_i
module spi_bit_counter #(
   parameter int W   = 9,
   parameter int MAX = 386
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [W-1:0] load_val_i,
   input  logic [W-1:0] tc_val_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   localparam logic [W-1:0] MAX_C = W'(MAX);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)                        cnt_d = '0;
      else if (load_i)                  cnt_d = load_val_i;
      else if (en_i && cnt_q != MAX_C)  cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/aes_spi_link.sv
// aes_spi_link: serial load/readback front-end for the AES core.
//   clk_i, rst_ni    bit/system clock, async active-low reset
//   cs_i, miso_i     host frame enable and serial data in (LSB first)
//   mosi_o           serial processed block out (LSB first)
//   key_out_o        received key, LSB aligned, upper bits zero
//   msg_out_o        received message block
//   key_len_o        128/192/256 after a good load, else 0
//   load_valid_o     one-cycle strobe: key/msg/key_len valid
//   proc_in_i        processed block from the core
//   proc_valid_i     single-cycle strobe qualifying proc_in_i
//   tx_ready_o       processed block latched, next frame is a read
//   frame_err_o      sticky bad-load flag, cleared by next good load
//   state_o          current link state (debug)
// Handshake: load_valid_o is a pulse with no back-pressure; the core must
// capture on that cycle. proc_valid_i is accepted only in WAIT_PROC and
// is a single-cycle strobe; there is no ready towards the core.
module aes_spi_link
   import aes_spi_pkg::*;
#(
   parameter int BLK_W   = 128,
   parameter int KEY_MAX = 256
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               cs_i,
   input  logic               miso_i,
   output logic               mosi_o,
   output logic [KEY_MAX-1:0] key_out_o,
   output logic [BLK_W-1:0]   msg_out_o,
   output logic [8:0]         key_len_o,
   output logic               load_valid_o,
   input  logic [BLK_W-1:0]   proc_in_i,
   input  logic               proc_valid_i,
   output logic               tx_ready_o,
   output logic               frame_err_o,
   output state_t             state_o
);

   localparam int FRAME_MAX = HDR_W + BLK_W + KEY_MAX;
   localparam int CNT_W     = $clog2(FRAME_MAX + 1);

   localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);
   localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(HDR_W + BLK_W - 1);

   state_t               state_q;
   logic                 hdr0_q;
   logic [8:0]           klen_sh_q;
   logic [BLK_W-1:0]     msg_sh_q;
   logic [KEY_MAX-1:0]   key_sh_q;
   logic [KEY_MAX-1:0]   key_out_q;
   logic [BLK_W-1:0]     msg_out_q;
   logic [8:0]           key_len_q;
   logic                 load_valid_q;
   logic                 frame_err_q;
   logic [BLK_W-1:0]     tx_sr_q;
   logic                 tx_ready_q;
   logic                 mosi_q;

   logic [CNT_W-1:0]     cnt;
   logic                 cnt_tc;
   logic                 cnt_clr_d, cnt_load_d, cnt_en_d;
   logic [CNT_W-1:0]     tc_val_d;

   // Counter holds the number of bits consumed in the current frame.
   // KEY stops counting once the key is complete so the compare stays true
   // while trailing bits are ignored.
   always_comb begin
      cnt_clr_d  = !cs_i || state_q == ST_CHECK || state_q == ST_WAIT_PROC;
      cnt_load_d = cs_i && (state_q == ST_IDLE || state_q == ST_TX_ARMED);
      cnt_en_d   = 1'b0;
      tc_val_d   = '0;
      unique case (state_q)
         ST_HDR, ST_MSG: cnt_en_d = cs_i;
         ST_KEY: begin
            tc_val_d = CNT_W'(HDR_W + BLK_W) + CNT_W'(klen_sh_q);
            cnt_en_d = cs_i && !cnt_tc;
         end
         ST_TX: begin
            tc_val_d = CNT_W'(BLK_W);
            cnt_en_d = cs_i && !cnt_tc;
         end
         default: ;
      endcase
   end

   spi_bit_counter #(
      .W   (CNT_W),
      .MAX (FRAME_MAX)
   ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (cnt_clr_d),
      .load_i     (cnt_load_d),
      .en_i       (cnt_en_d),
      .load_val_i (CNT_W'(1)),
      .tc_val_i   (tc_val_d),
      .cnt_o      (cnt),
      .tc_o       (cnt_tc)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         hdr0_q       <= 1'b0;
         klen_sh_q    <= '0;
         msg_sh_q     <= '0;
         key_sh_q     <= '0;
         key_out_q    <= '0;
         msg_out_q    <= '0;
         key_len_q    <= '0;
         load_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         tx_sr_q      <= '0;
         tx_ready_q   <= 1'b0;
         mosi_q       <= 1'b0;
      end else begin
         load_valid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (cs_i) begin
                  hdr0_q  <= miso_i;
                  state_q <= ST_HDR;
               end
            end
            // A reserved header parks here (count moves past HDR_LAST) until cs drops.
            ST_HDR: begin
               if (!cs_i) begin
                  frame_err_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else if (cnt == HDR_LAST) begin
                  if ({miso_i, hdr0_q} == KS_RSVD) begin
                     frame_err_q <= 1'b1;
                  end else begin
                     klen_sh_q <= hdr_to_len({miso_i, hdr0_q});
                     state_q   <= ST_MSG;
                  end
               end
            end
            ST_MSG: begin
               if (!cs_i) begin
                  frame_err_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else begin
                  msg_sh_q <= {miso_i, msg_sh_q[BLK_W-1:1]};
                  if (cnt == MSG_LAST) state_q <= ST_KEY;
               end
            end
            // Key bits enter at the top; at commit the received bits are
            // shifted down to bit 0 so shorter keys come out zero-extended.
            ST_KEY: begin
               if (!cs_i) begin
                  if (cnt_tc) begin
                     key_out_q    <= key_sh_q >> (KEY_MAX - int'(klen_sh_q));
                     msg_out_q    <= msg_sh_q;
                     key_len_q    <= klen_sh_q;
                     load_valid_q <= 1'b1;
                     frame_err_q  <= 1'b0;
                     state_q      <= ST_CHECK;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= ST_IDLE;
                  end
               end else if (!cnt_tc) begin
                  key_sh_q <= {miso_i, key_sh_q[KEY_MAX-1:1]};
               end
            end
            ST_CHECK: state_q <= ST_WAIT_PROC;
            ST_WAIT_PROC: begin
               if (proc_valid_i) begin
                  tx_sr_q    <= proc_in_i;
                  mosi_q     <= proc_in_i[0];
                  tx_ready_q <= 1'b1;
                  state_q    <= ST_TX_ARMED;
               end
            end
            // The frame's first edge samples bit 0, so it also shifts.
            ST_TX_ARMED: begin
               if (cs_i) begin
                  tx_sr_q <= tx_sr_q >> 1;
                  mosi_q  <= tx_sr_q[1];
                  state_q <= ST_TX;
               end
            end
            ST_TX: begin
               if (!cs_i) begin
                  tx_sr_q    <= '0;
                  mosi_q     <= 1'b0;
                  tx_ready_q <= 1'b0;
                  state_q    <= ST_IDLE;
               end else if (!cnt_tc) begin
                  tx_sr_q <= tx_sr_q >> 1;
                  mosi_q  <= tx_sr_q[1];
               end else begin
                  mosi_q <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mosi_o       = mosi_q;
   assign key_out_o    = key_out_q;
   assign msg_out_o    = msg_out_q;
   assign key_len_o    = key_len_q;
   assign load_valid_o = load_valid_q;
   assign tx_ready_o   = tx_ready_q;
   assign frame_err_o  = frame_err_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_aes_spi_link.sv
// tb_aes_spi_link: directed + randomized bench for aes_spi_link.
// Expected values come from a frame-level model: a good load replaces
// key/msg/key_len (key masked to its length), a bad one only sets the
// error flag; a read frame returns the processed block LSB first then 0.
module tb_aes_spi_link;
   import aes_spi_pkg::*;

   localparam int BLK_W   = 128;
   localparam int KEY_MAX = 256;

   logic               clk_i = 1'b0;
   logic               rst_ni = 1'b0;
   logic               cs_i = 1'b0;
   logic               miso_i = 1'b0;
   logic               mosi_o;
   logic [KEY_MAX-1:0] key_out_o;
   logic [BLK_W-1:0]   msg_out_o;
   logic [8:0]         key_len_o;
   logic               load_valid_o;
   logic [BLK_W-1:0]   proc_in_i = '0;
   logic               proc_valid_i = 1'b0;
   logic               tx_ready_o;
   logic               frame_err_o;
   state_t             state_o;

   int total = 0;
   int bad   = 0;

   // frame-level reference state
   logic [255:0] m_key = '0;
   logic [127:0] m_msg = '0;
   logic [8:0]   m_klen = '0;
   logic         m_err = 1'b0;

   aes_spi_link #(.BLK_W(BLK_W), .KEY_MAX(KEY_MAX)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cs_i         (cs_i),
      .miso_i       (miso_i),
      .mosi_o       (mosi_o),
      .key_out_o    (key_out_o),
      .msg_out_o    (msg_out_o),
      .key_len_o    (key_len_o),
      .load_valid_o (load_valid_o),
      .proc_in_i    (proc_in_i),
      .proc_valid_i (proc_valid_i),
      .tx_ready_o   (tx_ready_o),
      .frame_err_o  (frame_err_o),
      .state_o      (state_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check_model(input string tag);
      check({tag, ".key_out"}, key_out_o, m_key);
      check({tag, ".msg_out"}, 256'(msg_out_o), 256'(m_msg));
      check({tag, ".key_len"}, 256'(key_len_o), 256'(m_klen));
      check({tag, ".frame_err"}, 256'(frame_err_o), 256'(m_err));
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".mosi"}, 256'(mosi_o), '0);
      check({tag, ".load_valid"}, 256'(load_valid_o), '0);
      check({tag, ".tx_ready"}, 256'(tx_ready_o), '0);
      check({tag, ".state"}, 256'(state_o), 256'(ST_IDLE));
      check_model(tag);
   endtask

   // Drive nbits of a load frame with cs held high; proc_valid toggles
   // randomly since it must be ignored outside WAIT_PROC.
   task automatic send_bits(input logic [1:0] hdr, input logic [127:0] msg,
                            input logic [255:0] key, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         logic b;
         if (i < 2)        b = hdr[i];
         else if (i < 130) b = msg[i-2];
         else if (i < 386) b = key[i-130];
         else              b = 1'($urandom);
         @(negedge clk_i);
         cs_i         = 1'b1;
         miso_i       = b;
         proc_valid_i = 1'($urandom_range(0, 1));
         proc_in_i    = rnd256()[127:0];
      end
   endtask

   task automatic run_load(input logic [1:0] hdr, input logic [127:0] msg,
                           input logic [255:0] key, input int nbits, output bit good);
      int klen;
      klen = (hdr == 2'd0) ? 128 : (hdr == 2'd1) ? 192 : 256;
      good = (hdr != 2'd3) && (nbits >= 2 + BLK_W + klen);
      send_bits(hdr, msg, key, nbits);
      @(negedge clk_i);
      cs_i = 1'b0; miso_i = 1'b0; proc_valid_i = 1'b0;
      if (good) begin
         m_key = '0;
         for (int i = 0; i < klen; i++) m_key[i] = key[i];
         m_msg  = msg;
         m_klen = 9'(klen);
         m_err  = 1'b0;
      end else begin
         m_err = 1'b1;
      end
      @(negedge clk_i);
      check("load.load_valid", 256'(load_valid_o), 256'(good));
      check("load.tx_ready", 256'(tx_ready_o), '0);
      check("load.state", 256'(state_o), good ? 256'(ST_CHECK) : 256'(ST_IDLE));
      check_model("load");
      @(negedge clk_i);
      check("load.pulse_end", 256'(load_valid_o), '0);
      check("load.state2", 256'(state_o), good ? 256'(ST_WAIT_PROC) : 256'(ST_IDLE));
   endtask

   task automatic run_read(input logic [127:0] proc, input int nclk);
      logic [255:0] obs, exp;
      logic         e_after;
      @(negedge clk_i);
      proc_in_i = proc; proc_valid_i = 1'b1;
      @(negedge clk_i);
      proc_valid_i = 1'b0; proc_in_i = ~proc;
      check("read.tx_ready", 256'(tx_ready_o), 256'(1));
      check("read.armed", 256'(state_o), 256'(ST_TX_ARMED));
      obs = '0; exp = '0;
      for (int n = 0; n < nclk; n++) begin
         obs[n] = mosi_o;
         if (n < BLK_W) exp[n] = proc[n];
         cs_i = 1'b1;
         @(negedge clk_i);
      end
      check("read.mosi_stream", obs, exp);
      e_after = (nclk < BLK_W) ? proc[nclk] : 1'b0;
      check("read.mosi_after", 256'(mosi_o), 256'(e_after));
      cs_i = 1'b0;
      @(negedge clk_i);
      check("read.tx_ready_clr", 256'(tx_ready_o), '0);
      check("read.idle", 256'(state_o), 256'(ST_IDLE));
      check("read.mosi_idle", 256'(mosi_o), '0);
   endtask

   initial begin
      bit good;
      int hdr, klen, full, mode, nbits;

      repeat (3) @(negedge clk_i);
      check_reset("por");
      rst_ni = 1'b1;

      // directed 256-bit load and known read-back block
      run_load(2'b10, 128'h00112233_44556677_8899AABB_CCDDEEFF,
               256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F,
               386, good);
      run_read(128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A, 128);

      // 192-bit key with trailing bits
      run_load(2'b01, rnd256()[127:0], rnd256(), 2 + 128 + 192 + 5, good);
      check("k192.upper_zero", 256'(key_out_o[255:192]), '0);
      run_read(rnd256()[127:0], 131);

      // short frame inside the message
      run_load(2'b00, rnd256()[127:0], rnd256(), 2 + 100, good);

      // proc_valid outside WAIT_PROC
      @(negedge clk_i); proc_valid_i = 1'b1; proc_in_i = rnd256()[127:0];
      @(negedge clk_i); proc_valid_i = 1'b0;
      check("idle_proc.tx_ready", 256'(tx_ready_o), '0);
      check("idle_proc.state", 256'(state_o), 256'(ST_IDLE));

      // good frame clears the error
      run_load(2'b00, rnd256()[127:0], rnd256(), 2 + 128 + 128, good);
      run_read(rnd256()[127:0], 128);

      // reserved header
      run_load(2'b11, rnd256()[127:0], rnd256(), 60, good);

      // randomized frames
      for (int it = 0; it < 10; it++) begin
         hdr  = $urandom_range(0, 3);
         klen = (hdr == 0) ? 128 : (hdr == 1) ? 192 : 256;
         full = 2 + BLK_W + klen;
         mode = $urandom_range(0, 2);
         if (hdr == 3)       nbits = $urandom_range(1, 400);
         else if (mode == 0) nbits = full;
         else if (mode == 1) nbits = full + $urandom_range(1, 8);
         else                nbits = $urandom_range(1, full - 1);
         run_load(2'(hdr), rnd256()[127:0], rnd256(), nbits, good);
         if (good) run_read(rnd256()[127:0],
                            ($urandom_range(0, 1) == 1) ? 128 + $urandom_range(0, 4)
                                                         : $urandom_range(1, 127));
      end

      // reset in the middle of the key
      send_bits(2'b10, rnd256()[127:0], rnd256(), 180);
      @(negedge clk_i);
      rst_ni = 1'b0; cs_i = 1'b0; proc_valid_i = 1'b0;
      m_key = '0; m_msg = '0; m_klen = '0; m_err = 1'b0;
      #1 check_reset("rst_key");
      @(negedge clk_i); rst_ni = 1'b1;

      // reset in the middle of a read frame
      run_load(2'b00, rnd256()[127:0], rnd256(), 2 + 128 + 128, good);
      @(negedge clk_i); proc_in_i = rnd256()[127:0]; proc_valid_i = 1'b1;
      @(negedge clk_i); proc_valid_i = 1'b0;
      for (int n = 0; n < 60; n++) begin
         cs_i = 1'b1;
         @(negedge clk_i);
      end
      rst_ni = 1'b0; cs_i = 1'b0;
      m_key = '0; m_msg = '0; m_klen = '0; m_err = 1'b0;
      #1 check_reset("rst_tx");
      @(negedge clk_i); rst_ni = 1'b1;

      // proc_valid before the next good load
      @(negedge clk_i); proc_valid_i = 1'b1; proc_in_i = rnd256()[127:0];
      @(negedge clk_i); proc_valid_i = 1'b0;
      check("post_rst_proc.tx_ready", 256'(tx_ready_o), '0);
      check("post_rst_proc.state", 256'(state_o), 256'(ST_IDLE));

      run_load(2'b10, rnd256()[127:0], rnd256(), 386, good);
      run_read(rnd256()[127:0], 130);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
